// File: rtl/paddle_render.sv
// Paddle renderer: on each accepted draw, optionally erases the paddle, applies one
// clamped move, then redraws it pixel by pixel for a framebuffer writer.
module paddle_render #(
  parameter int         PLAT_W    = 20,
  parameter int         PLAT_H    = 2,
  parameter int         PLAT_Y    = 64,
  parameter int         SCREEN_W  = 160,
  parameter int         STEP      = 1,
  parameter int         INIT_X    = 32,
  parameter int         ERASE_EN  = 1,
  parameter logic [2:0] COLOUR    = 3'b100,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       draw,
  input  logic       enable,
  input  logic       left,
  input  logic       right,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [2:0] colour,
  output logic       writeEn,
  output logic [9:0] pos_x,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ERASE = 3'd1;
  localparam logic [2:0] S_MOVE  = 3'd2;
  localparam logic [2:0] S_DRAW  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [9:0] MAX_X   = 10'(SCREEN_W - PLAT_W);
  localparam logic [9:0] STEP_V  = 10'(STEP);
  localparam logic [9:0] INIT_V  = 10'(INIT_X);
  localparam logic [9:0] LAST_QX = 10'(PLAT_W - 1);
  localparam logic [9:0] LAST_QY = 10'(PLAT_H - 1);
  localparam logic [9:0] Y0      = 10'(PLAT_Y);

  logic [2:0] state_r;
  logic [9:0] pos_r;
  logic [9:0] qx_r;
  logic [9:0] qy_r;
  logic       mv_l_r;
  logic       mv_r_r;
  logic [9:0] next_pos_s;
  logic       paint_s;

  // Clamped next position; arithmetic stays 10-bit because pos_r never exceeds MAX_X.
  always_comb begin
    next_pos_s = pos_r;
    if (mv_l_r && !mv_r_r) begin
      next_pos_s = (pos_r >= STEP_V) ? (pos_r - STEP_V) : 10'd0;
    end else if (mv_r_r && !mv_l_r) begin
      next_pos_s = ((pos_r + STEP_V) <= MAX_X) ? (pos_r + STEP_V) : MAX_X;
    end else begin
      next_pos_s = pos_r;
    end
  end

  // Pass sequencer, scan counters, latched move request and paddle position.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= S_IDLE;
      pos_r   <= INIT_V;
      qx_r    <= 10'd0;
      qy_r    <= 10'd0;
      mv_l_r  <= 1'b0;
      mv_r_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (draw) begin
            mv_l_r  <= enable & left;
            mv_r_r  <= enable & right;
            state_r <= (ERASE_EN != 0) ? S_ERASE : S_MOVE;
          end
        end
        S_ERASE, S_DRAW: begin
          // Counters return to zero at the end of a scan so x/y idle at the paddle origin.
          if (qx_r == LAST_QX) begin
            qx_r <= 10'd0;
            if (qy_r == LAST_QY) begin
              qy_r    <= 10'd0;
              state_r <= (state_r == S_ERASE) ? S_MOVE : S_DONE;
            end else begin
              qy_r <= qy_r + 10'd1;
            end
          end else begin
            qx_r <= qx_r + 10'd1;
          end
        end
        S_MOVE: begin
          pos_r   <= next_pos_s;
          state_r <= S_DRAW;
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          qx_r    <= 10'd0;
          qy_r    <= 10'd0;
        end
      endcase
    end
  end

  // Pixel stream and status, decoded from registered state only.
  always_comb begin
    paint_s = (state_r == S_ERASE) || (state_r == S_DRAW);
    writeEn = paint_s;
    x       = pos_r + qx_r;
    y       = Y0 + qy_r;
    colour  = (state_r == S_ERASE) ? BG_COLOUR : COLOUR;
    pos_x   = pos_r;
    busy    = (state_r != S_IDLE);
    done    = (state_r == S_DONE);
  end

endmodule

// File: tb/tb_paddle_render.sv
// Scoreboard bench for paddle_render: four parameterisations, randomized move requests,
// expected pixel/done events queued by a reference model and checked by a monitor.
module tb_paddle_render;

  typedef struct {
    int g;
    int cyc;
    int kind;   // 0 = pixel, 1 = done pulse
    int px;
    int py;
    int col;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn [4];
  logic       drw  [4];
  logic       en   [4];
  logic       lf   [4];
  logic       rt   [4];
  logic [9:0] ox   [4];
  logic [9:0] oy   [4];
  logic [9:0] opos [4];
  logic [2:0] ocol [4];
  logic       owe  [4];
  logic       obusy[4];
  logic       odone[4];

  int cw[4]    = '{20, 20, 20, 8};
  int ch[4]    = '{2, 2, 2, 3};
  int cstep[4] = '{1, 4, 4, 1};
  int cinit[4] = '{32, 138, 2, 32};
  int cer[4]   = '{1, 1, 1, 0};

  int   mpos[4];
  int   we_cnt[4];
  int   done_cnt[4];
  int   done_cyc[4];
  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  paddle_render #(.PLAT_W(20), .PLAT_H(2), .STEP(1), .INIT_X(32), .ERASE_EN(1)) u0 (
    .clk(clk), .resetn(rstn[0]), .draw(drw[0]), .enable(en[0]), .left(lf[0]), .right(rt[0]),
    .x(ox[0]), .y(oy[0]), .colour(ocol[0]), .writeEn(owe[0]), .pos_x(opos[0]),
    .busy(obusy[0]), .done(odone[0]));
  paddle_render #(.PLAT_W(20), .PLAT_H(2), .STEP(4), .INIT_X(138), .ERASE_EN(1)) u1 (
    .clk(clk), .resetn(rstn[1]), .draw(drw[1]), .enable(en[1]), .left(lf[1]), .right(rt[1]),
    .x(ox[1]), .y(oy[1]), .colour(ocol[1]), .writeEn(owe[1]), .pos_x(opos[1]),
    .busy(obusy[1]), .done(odone[1]));
  paddle_render #(.PLAT_W(20), .PLAT_H(2), .STEP(4), .INIT_X(2), .ERASE_EN(1)) u2 (
    .clk(clk), .resetn(rstn[2]), .draw(drw[2]), .enable(en[2]), .left(lf[2]), .right(rt[2]),
    .x(ox[2]), .y(oy[2]), .colour(ocol[2]), .writeEn(owe[2]), .pos_x(opos[2]),
    .busy(obusy[2]), .done(odone[2]));
  paddle_render #(.PLAT_W(8), .PLAT_H(3), .STEP(1), .INIT_X(32), .ERASE_EN(0)) u3 (
    .clk(clk), .resetn(rstn[3]), .draw(drw[3]), .enable(en[3]), .left(lf[3]), .right(rt[3]),
    .x(ox[3]), .y(oy[3]), .colour(ocol[3]), .writeEn(owe[3]), .pos_x(opos[3]),
    .busy(obusy[3]), .done(odone[3]));

  task automatic check(input string nm, input int got, input int expv);
    n_chk++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int model_move(input int p, input bit ml, input bit mr, input int step, input int maxx);
    if (ml && !mr) return (p >= step) ? p - step : 0;
    if (mr && !ml) return (p + step <= maxx) ? p + step : maxx;
    return p;
  endfunction

  task automatic push_item(input int g, input int c, input int k, input int px, input int py, input int col);
    exp_t e;
    e.g = g; e.cyc = c; e.kind = k; e.px = px; e.py = py; e.col = col;
    sb.push_back(e);
  endtask

  // Monitor: every pixel strobe or done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 4; g++) begin
      if (owe[g] || odone[g]) begin
        if (owe[g]) we_cnt[g]++;
        if (odone[g]) begin
          done_cnt[g]++;
          done_cyc[g] = cyc;
        end
        if (sb.size() == 0) begin
          check("unexpected_output", g, -1);
        end else begin
          e = sb.pop_front();
          check("item_inst", g, e.g);
          check("item_cycle", cyc, e.cyc);
          check("item_kind", int'(odone[g]) + 2 * int'(owe[g]), (e.kind == 1) ? 1 : 2);
          check("item_x", int'(ox[g]), e.px);
          check("item_y", int'(oy[g]), e.py);
          check("item_colour", int'(ocol[g]), e.col);
        end
      end else if (rstn[g]) begin
        check("idle_outputs", int'({ox[g] == opos[g], oy[g] == 10'd64, ocol[g] == 3'd4}), 7);
      end
    end
  end

  // One full pass: queue expected events, issue draw, jiggle move inputs, optionally abort.
  task automatic run_pass(input int g, input bit e, input bit l, input bit r,
                          input bit repulse, input int abort_at, output int a);
    bit ml, mr, fin;
    int n, p, base;
    ml = e & l;
    mr = e & r;
    n  = cw[g] * ch[g];
    a  = cyc;
    p  = mpos[g];
    if (cer[g] != 0) begin
      for (int qy = 0; qy < ch[g]; qy++)
        for (int qx = 0; qx < cw[g]; qx++)
          push_item(g, a + 1 + qy * cw[g] + qx, 0, p + qx, 64 + qy, 0);
    end
    base = (cer[g] != 0) ? a + n + 2 : a + 2;
    p = model_move(p, ml, mr, cstep[g], 160 - cw[g]);
    mpos[g] = p;
    for (int qy = 0; qy < ch[g]; qy++)
      for (int qx = 0; qx < cw[g]; qx++)
        push_item(g, base + qy * cw[g] + qx, 0, p + qx, 64 + qy, 4);
    push_item(g, base + n, 1, p, 64, 4);

    drw[g] = 1'b1; en[g] = e; lf[g] = l; rt[g] = r;
    tick();
    drw[g] = 1'b0;
    fin = 1'b0;
    for (int k = 1; k < 300 && !fin; k++) begin
      en[g]  = 1'($urandom_range(0, 1));
      lf[g]  = 1'($urandom_range(0, 1));
      rt[g]  = 1'($urandom_range(0, 1));
      drw[g] = repulse && (k == 10);
      if (abort_at != 0 && k == abort_at) begin
        rstn[g] = 1'b0;
        while (sb.size() != 0 && sb[$].cyc > a + k) void'(sb.pop_back());
        mpos[g] = cinit[g];
        tick();
        check("abort_writeEn", int'(owe[g]), 0);
        check("abort_busy", int'(obusy[g]), 0);
        rstn[g] = 1'b1;
        fin = 1'b1;
      end else begin
        tick();
        if (!obusy[g]) fin = 1'b1;
      end
    end
    drw[g] = 1'b0;
    if (!fin) check("pass_timeout", 0, 1);
    repeat (4) tick();
    check("sb_drained", sb.size(), 0);
    check("idle_after_pass", int'(obusy[g]), 0);
    check("pos_x_model", int'(opos[g]), mpos[g]);
  endtask

  task automatic random_passes(input int g, input int cnt);
    int a;
    for (int i = 0; i < cnt; i++)
      run_pass(g, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'b0, 0, a);
  endtask

  initial begin
    int a;
    for (int g = 0; g < 4; g++) begin
      rstn[g] = 1'b0; drw[g] = 1'b0; en[g] = 1'b0; lf[g] = 1'b0; rt[g] = 1'b0;
      we_cnt[g] = 0; done_cnt[g] = 0; done_cyc[g] = 0;
    end
    tick();
    // Draw asserted alongside reset must be ignored.
    drw[0] = 1'b1;
    tick();
    tick();
    drw[0] = 1'b0;
    for (int g = 0; g < 4; g++) rstn[g] = 1'b1;
    for (int g = 0; g < 4; g++) begin
      mpos[g] = cinit[g];
      check("reset_pos_x", int'(opos[g]), cinit[g]);
      check("reset_busy", int'(obusy[g]), 0);
      check("reset_writeEn", int'(owe[g]), 0);
      check("reset_done", int'(odone[g]), 0);
    end

    // Defaults, no move.
    run_pass(0, 1'b0, 1'b0, 1'b0, 1'b0, 0, a);
    check("default_done_cycle", done_cyc[0] - a, 82);
    check("default_pos_x", int'(opos[0]), 32);
    check("default_we_count", we_cnt[0], 80);

    // Draw re-pulsed mid-pass is dropped.
    we_cnt[0] = 0; done_cnt[0] = 0;
    run_pass(0, 1'b1, 1'b1, 1'b0, 1'b1, 0, a);
    check("busy_we_count", we_cnt[0], 80);
    check("busy_done_count", done_cnt[0], 1);
    check("busy_pos_x", int'(opos[0]), 31);

    // Reset during erase.
    we_cnt[0] = 0; done_cnt[0] = 0;
    run_pass(0, 1'b1, 1'b0, 1'b1, 1'b0, 15, a);
    check("abort_we_count", we_cnt[0], 15);
    check("abort_done_count", done_cnt[0], 0);
    check("abort_pos_x", int'(opos[0]), 32);
    random_passes(0, 6);

    // Right clamp.
    run_pass(1, 1'b1, 1'b0, 1'b1, 1'b0, 0, a);
    check("rclamp_pos_x", int'(opos[1]), 140);
    run_pass(1, 1'b1, 1'b0, 1'b1, 1'b0, 0, a);
    check("rclamp_repeat_pos_x", int'(opos[1]), 140);
    random_passes(1, 3);

    // Left clamp then conflicting request.
    run_pass(2, 1'b1, 1'b1, 1'b0, 1'b0, 0, a);
    check("lclamp_pos_x", int'(opos[2]), 0);
    run_pass(2, 1'b1, 1'b1, 1'b1, 1'b0, 0, a);
    check("conflict_pos_x", int'(opos[2]), 0);
    random_passes(2, 3);

    // Draw-only configuration.
    we_cnt[3] = 0;
    run_pass(3, 1'b1, 1'b0, 1'b1, 1'b0, 0, a);
    check("noerase_done_cycle", done_cyc[3] - a, 26);
    check("noerase_we_count", we_cnt[3], 24);
    check("noerase_pos_x", int'(opos[3]), 33);
    random_passes(3, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
